// File: rtl/uart_ctrl.sv
// Host-side sequencer for a UART with a shared bidirectional data bus: queues host
// transmit bytes, arbitrates TX drain against RX collection, exposes valid/ready streams.
module uart_ctrl #(
  parameter int TXQ_DEPTH     = 4,
  parameter int STROBE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  inout  wire  [7:0] uart_data,
  output logic       uart_wr,
  output logic       uart_rd,
  output logic       uart_ce,
  input  logic       uart_dbf,
  input  logic       uart_rdc,
  input  logic       uart_error,
  output logic       err_sticky,
  input  logic       clr_err,
  output logic       busy
);
  localparam int AW = $clog2(TXQ_DEPTH);
  localparam logic [AW:0] DEPTH_C     = (AW+1)'(TXQ_DEPTH);
  localparam logic [3:0]  STROBE_LAST = 4'(STROBE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, WR_SETUP, WR_STROBE, RD_STROBE, TURN} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          last_rx_q, last_rx_d;
  logic [7:0]    mem_q [TXQ_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [7:0]    wdata_q;
  logic [7:0]    rx_data_q;
  logic          rx_valid_q, err_q;
  logic          push, pop, capture, strobe_last, tx_req, rx_req, drive_bus;

  assign tx_ready    = (count_q < DEPTH_C);
  assign push        = tx_valid && tx_ready;
  assign strobe_last = (cnt_q == STROBE_LAST);
  assign pop         = (state_q == WR_STROBE) && strobe_last;
  assign capture     = (state_q == RD_STROBE) && strobe_last;
  assign tx_req      = (count_q != '0) && !uart_dbf;
  assign rx_req      = uart_rdc && !rx_valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_rx_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_rx_q <= last_rx_d;
    end
  end

  // On a tie, last_rx_q=0 (TX granted last) hands the bus to RX.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_rx_d = last_rx_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (tx_req && (!rx_req || last_rx_q)) begin
          state_d   = WR_SETUP;
          last_rx_d = 1'b0;
        end else if (rx_req) begin
          state_d   = RD_STROBE;
          last_rx_d = 1'b1;
        end
      end
      WR_SETUP: state_d = WR_STROBE;
      WR_STROBE, RD_STROBE: begin
        cnt_d = cnt_q + 4'd1;
        if (strobe_last) begin
          state_d = TURN;
          cnt_d   = '0;
        end
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    uart_ce   = 1'b0;
    uart_wr   = 1'b0;
    uart_rd   = 1'b0;
    drive_bus = 1'b0;
    case (state_q)
      WR_SETUP:  begin uart_ce = 1'b1; drive_bus = 1'b1; end
      WR_STROBE: begin uart_ce = 1'b1; uart_wr = 1'b1; drive_bus = 1'b1; end
      RD_STROBE: begin uart_ce = 1'b1; uart_rd = 1'b1; end
      default: ;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign uart_data = drive_bus ? wdata_q : 8'hzz;

  // The head is re-read every IDLE cycle so it is already registered when WR_SETUP starts.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
    if (state_q == IDLE) wdata_q <= mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (capture) begin
        rx_data_q  <= uart_data;
        rx_valid_q <= 1'b1;
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
      if (capture && uart_error) err_q <= 1'b1;
      else if (clr_err)          err_q <= 1'b0;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign err_sticky = err_q;
endmodule

// File: tb/tb_uart_ctrl.sv
// Self-checking bench for uart_ctrl: directed scenarios plus randomized traffic
// checked against a queue-based model of the host and UART sides.
module tb_uart_ctrl;
  localparam int SC = 2;

  logic clk = 1'b0, rst = 1'b0;
  logic [7:0] tx_data = 8'h00, uart_byte = 8'h00;
  logic tx_valid = 1'b0, rx_ready = 1'b0, uart_dbf = 1'b0, uart_rdc = 1'b0;
  logic uart_error = 1'b0, clr_err = 1'b0;
  logic tx_ready, rx_valid, uart_wr, uart_rd, uart_ce, err_sticky, busy;
  logic [7:0] rx_data;
  wire  [7:0] uart_data;

  int errors = 0, checks = 0;
  int wr_starts = 0, rd_starts = 0, rd_done = 0, bad_len = 0, wr_len = 0, rd_len = 0;
  logic prev_wr = 1'b0, prev_rd = 1'b0;
  logic [7:0] wr_bytes[$];
  logic [8:0] ev_q[$];

  // The UART side answers a read strobe by driving its byte.
  assign uart_data = uart_rd ? uart_byte : 8'hzz;

  uart_ctrl #(.TXQ_DEPTH(4), .STROBE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .uart_data(uart_data),
    .uart_wr(uart_wr), .uart_rd(uart_rd), .uart_ce(uart_ce), .uart_dbf(uart_dbf),
    .uart_rdc(uart_rdc), .uart_error(uart_error), .err_sticky(err_sticky),
    .clr_err(clr_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  // An undriven bus reads as z in four-state simulators and as 0 in two-state ones.
  function automatic logic floating(input logic [7:0] v);
    return (v === 8'hzz) || (v === 8'h00);
  endfunction

  task automatic tick();
    @(posedge clk); #1;
    if (uart_wr && !prev_wr) begin
      wr_starts++; wr_bytes.push_back(uart_data); ev_q.push_back({1'b0, uart_data});
    end
    if (uart_rd && !prev_rd) begin rd_starts++; ev_q.push_back(9'h100); end
    if (!uart_rd && prev_rd) rd_done++;
    if (uart_wr) wr_len++;
    else if (prev_wr) begin if (wr_len != SC) bad_len++; wr_len = 0; end
    if (uart_rd) rd_len++;
    else if (prev_rd) begin if (rd_len != SC) bad_len++; rd_len = 0; end
    prev_wr = uart_wr;
    prev_rd = uart_rd;
  endtask

  task automatic clear_trackers();
    prev_wr = 1'b0; prev_rd = 1'b0; wr_len = 0; rd_len = 0;
    wr_starts = 0; rd_starts = 0; rd_done = 0;
    wr_bytes.delete(); ev_q.delete();
  endtask

  task automatic do_reset();
    tx_valid = 0; rx_ready = 0; uart_dbf = 0; uart_rdc = 0; uart_error = 0; clr_err = 0;
    rst = 0; #1;
    clear_trackers();
    tick(); tick();
    rst = 1;
    tick();
  endtask

  task automatic push_byte(input logic [7:0] b);
    int n = 0;
    tx_data = b; tx_valid = 1;
    while (!tx_ready && n < 50) begin tick(); n++; end
    checks++;
    if (tx_ready !== 1'b1) begin errors++; $display("FAIL push_accept: tx_ready=%b want 1", tx_ready); end
    tick();
    tx_valid = 0;
  endtask

  task automatic test_reset();
    rst = 0; tick(); tick();
    checks++; if (uart_wr !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b want 0", uart_wr); end
    checks++; if (uart_rd !== 1'b0) begin errors++; $display("FAIL reset_rd: got %b want 0", uart_rd); end
    checks++; if (uart_ce !== 1'b0) begin errors++; $display("FAIL reset_ce: got %b want 0", uart_ce); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_sticky); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
    checks++; if (!floating(uart_data)) begin errors++; $display("FAIL reset_bus: got %h want z", uart_data); end
    rst = 1; tick();
  endtask

  task automatic test_single_write();
    logic [3:0] exp_sig [5] = '{4'b1001, 4'b1101, 4'b1101, 4'b0001, 4'b0000};
    logic       exp_drv [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    uart_dbf = 0;
    push_byte(8'hA5);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_decide_idle: busy=%b want 0", busy); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({uart_ce, uart_wr, uart_rd, busy} !== exp_sig[i]) begin
        errors++; $display("FAIL write_seq[%0d]: ce/wr/rd/busy=%b want %b", i, {uart_ce, uart_wr, uart_rd, busy}, exp_sig[i]);
      end
      checks++;
      if (exp_drv[i] ? (uart_data !== 8'hA5) : !floating(uart_data)) begin
        errors++; $display("FAIL write_bus[%0d]: got %h want %s", i, uart_data, exp_drv[i] ? "a5" : "z");
      end
    end
    repeat (4) tick();
    checks++; if (wr_starts !== 1) begin errors++; $display("FAIL write_count: got %0d want 1", wr_starts); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL write_fifo_empty: tx_ready=%b want 1", tx_ready); end
  endtask

  task automatic test_fifo_full();
    int n = 0;
    wr_bytes.delete(); wr_starts = 0;
    uart_dbf = 1;
    for (int i = 1; i <= 4; i++) push_byte(8'(i));
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL full_tx_ready: got %b want 0", tx_ready); end
    tx_data = 8'h05; tx_valid = 1;
    repeat (3) tick();
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL full_stays: tx_ready=%b want 0", tx_ready); end
    tx_valid = 0;
    repeat (5) tick();
    checks++; if (wr_starts !== 0) begin errors++; $display("FAIL full_no_wr_while_dbf: writes=%0d want 0", wr_starts); end
    uart_dbf = 0;
    while (wr_bytes.size() < 4 && n < 60) begin tick(); n++; end
    repeat (10) tick();
    checks++; if (wr_bytes.size() !== 4) begin errors++; $display("FAIL full_drain_count: got %0d want 4", wr_bytes.size()); end
    for (int i = 0; i < 4 && i < wr_bytes.size(); i++) begin
      checks++;
      if (wr_bytes[i] !== 8'(i + 1)) begin errors++; $display("FAIL full_order[%0d]: got %h want %h", i, wr_bytes[i], 8'(i + 1)); end
    end
  endtask

  task automatic test_single_read();
    logic [3:0] exp_sig [4] = '{4'b1011, 4'b1011, 4'b0001, 4'b0000};
    rx_ready = 0; uart_byte = 8'h3C; uart_rdc = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({uart_ce, uart_wr, uart_rd, busy} !== exp_sig[i]) begin
        errors++; $display("FAIL read_seq[%0d]: ce/wr/rd/busy=%b want %b", i, {uart_ce, uart_wr, uart_rd, busy}, exp_sig[i]);
      end
      checks++;
      if (i < 2 ? (uart_data !== 8'h3C) : !floating(uart_data)) begin
        errors++; $display("FAIL read_bus[%0d]: got %h want %s", i, uart_data, i < 2 ? "3c" : "z");
      end
      if (i == 2) begin
        uart_rdc = 0;
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL read_rx_valid: got %b want 1", rx_valid); end
        checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL read_rx_data: got %h want 3c", rx_data); end
      end
    end
    rx_ready = 1; tick(); rx_ready = 0;
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL read_consume: rx_valid=%b want 0", rx_valid); end
  endtask

  task automatic test_arbitration();
    logic [8:0] exp_ev [4] = '{9'h100, 9'h011, 9'h100, 9'h022};
    int n = 0;
    do_reset();
    uart_dbf = 1;
    push_byte(8'h11);
    push_byte(8'h22);
    ev_q.delete();
    uart_byte = 8'h5A; rx_ready = 1; uart_dbf = 0; uart_rdc = 1;
    while (ev_q.size() < 4 && n < 60) begin tick(); n++; end
    checks++; if (ev_q.size() < 4) begin errors++; $display("FAIL arb_events: got %0d want 4", ev_q.size()); end
    for (int i = 0; i < 4 && i < ev_q.size(); i++) begin
      checks++;
      if (ev_q[i] !== exp_ev[i]) begin errors++; $display("FAIL arb_order[%0d]: got %h want %h", i, ev_q[i], exp_ev[i]); end
    end
    uart_rdc = 0;
    repeat (10) tick();
    rx_ready = 0;
  endtask

  task automatic test_error_holdoff();
    int n = 0, base;
    do_reset();
    uart_byte = 8'h77; uart_error = 1; uart_rdc = 1;
    while (rd_done == 0 && n < 30) begin tick(); n++; end
    uart_error = 0;
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL err_rx_valid: got %b want 1", rx_valid); end
    checks++; if (rx_data !== 8'h77) begin errors++; $display("FAIL err_rx_data: got %h want 77", rx_data); end
    checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", err_sticky); end
    base = rd_starts;
    repeat (10) tick();
    checks++; if (rd_starts !== base) begin errors++; $display("FAIL err_holdoff: reads=%0d want %0d", rd_starts, base); end
    uart_byte = 8'h99; uart_error = 1; rx_ready = 1;
    tick();
    rx_ready = 0;
    n = 0;
    while (!uart_rd && n < 10) begin tick(); n++; end
    repeat (SC - 1) tick();
    clr_err = 1;
    tick();
    checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL err_set_beats_clr: got %b want 1", err_sticky); end
    checks++; if (rx_data !== 8'h99) begin errors++; $display("FAIL err_second_byte: got %h want 99", rx_data); end
    tick();
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", err_sticky); end
    clr_err = 0; uart_error = 0; uart_rdc = 0; rx_ready = 1;
    tick();
    rx_ready = 0;
  endtask

  task automatic test_random_traffic();
    logic [7:0] tx_m[$];
    logic [7:0] rx_m[$];
    logic err_m = 1'b0, p_ce = 1'b0, p_rxv = 1'b0, capture;
    int seen_wr = 0, seen_rd = 0, seen_done = 0;
    do_reset();
    for (int cyc = 0; cyc < 1700; cyc++) begin
      bit drain = (cyc >= 1500);
      tick();
      if (wr_starts != seen_wr) begin
        seen_wr = wr_starts;
        checks++;
        if (tx_m.size() == 0 || uart_data !== tx_m[0]) begin
          errors++; $display("FAIL rand_tx_byte: got %h want %h", uart_data, tx_m.size() ? tx_m[0] : 8'h00);
        end
        if (tx_m.size() != 0) void'(tx_m.pop_front());
      end
      if (uart_ce && !uart_wr && !uart_rd && !p_ce) begin
        checks++; if (uart_dbf !== 1'b0) begin errors++; $display("FAIL rand_dbf: write granted with dbf=%b want 0", uart_dbf); end
      end
      if (rd_starts != seen_rd) begin
        seen_rd = rd_starts;
        checks++;
        if (!(uart_rdc && !p_rxv)) begin errors++; $display("FAIL rand_rd_grant: rdc=%b rx_valid=%b want 1/0", uart_rdc, p_rxv); end
      end
      capture = (rd_done != seen_done);
      seen_done = rd_done;
      if (capture) rx_m.push_back(uart_byte);
      if (capture && uart_error) err_m = 1'b1;
      else if (clr_err)          err_m = 1'b0;
      checks++; if (err_sticky !== err_m) begin errors++; $display("FAIL rand_err: got %b want %b", err_sticky, err_m); end
      checks++;
      if (rx_valid !== (rx_m.size() != 0)) begin errors++; $display("FAIL rand_rx_valid: got %b want %b", rx_valid, rx_m.size() != 0); end
      if (uart_rd) begin
        checks++; if (uart_data !== uart_byte) begin errors++; $display("FAIL rand_rd_bus: got %h want %h", uart_data, uart_byte); end
      end else if (!uart_ce) begin
        checks++; if (!floating(uart_data)) begin errors++; $display("FAIL rand_idle_bus: got %h want z", uart_data); end
      end
      if (capture) uart_rdc = 0;
      else if (!uart_rdc && !drain && $urandom_range(3) == 0) begin
        uart_byte = 8'($urandom); uart_error = ($urandom_range(7) == 0); uart_rdc = 1;
      end
      uart_dbf = !drain && ($urandom_range(2) == 0);
      clr_err  = !drain && ($urandom_range(9) == 0);
      rx_ready = drain || ($urandom_range(1) == 1);
      if (drain) tx_valid = 0;
      else begin tx_valid = ($urandom_range(1) == 1); tx_data = 8'($urandom); end
      if (tx_valid && tx_ready) tx_m.push_back(tx_data);
      if (rx_valid && rx_ready) begin
        checks++;
        if (rx_m.size() == 0 || rx_data !== rx_m[0]) begin
          errors++; $display("FAIL rand_rx_byte: got %h want %h", rx_data, rx_m.size() ? rx_m[0] : 8'h00);
        end
        if (rx_m.size() != 0) void'(rx_m.pop_front());
      end
      p_ce = uart_ce; p_rxv = rx_valid;
    end
    checks++; if (tx_m.size() != 0) begin errors++; $display("FAIL rand_tx_drained: left=%0d want 0", tx_m.size()); end
    checks++; if (rx_m.size() != 0) begin errors++; $display("FAIL rand_rx_drained: left=%0d want 0", rx_m.size()); end
    rx_ready = 0;
  endtask

  task automatic test_reset_mid_write();
    int n = 0;
    do_reset();
    uart_dbf = 1;
    push_byte(8'hAA);
    push_byte(8'hBB);
    uart_dbf = 0;
    while (!uart_wr && n < 20) begin tick(); n++; end
    checks++; if (uart_wr !== 1'b1) begin errors++; $display("FAIL rstw_reach_strobe: wr=%b want 1", uart_wr); end
    rst = 0; #1;
    checks++; if (uart_wr !== 1'b0) begin errors++; $display("FAIL rstw_wr: got %b want 0", uart_wr); end
    checks++; if (uart_ce !== 1'b0) begin errors++; $display("FAIL rstw_ce: got %b want 0", uart_ce); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstw_busy: got %b want 0", busy); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rstw_tx_ready: got %b want 1", tx_ready); end
    checks++; if (!floating(uart_data)) begin errors++; $display("FAIL rstw_bus: got %h want z", uart_data); end
    clear_trackers();
    tick();
    rst = 1;
    repeat (12) tick();
    checks++; if (wr_starts !== 0) begin errors++; $display("FAIL rstw_fifo_empty: writes=%0d want 0", wr_starts); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rstw_ready_after: got %b want 1", tx_ready); end
  endtask

  task automatic test_strobe_lengths();
    checks++; if (bad_len !== 0) begin errors++; $display("FAIL strobe_length: bad pulses=%0d want 0", bad_len); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_fifo_full();
    test_single_read();
    test_arbitration();
    test_error_holdoff();
    test_random_traffic();
    test_reset_mid_write();
    test_strobe_lengths();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
